nano_mem_responder: RTL and testbench



---
 rtl/nano_mem_responder.sv | 113 +++++++++++
 tb/tb_nano_mem_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nano_mem_responder.sv
// Avalon-MM responder: word RAM with byte-lane writes plus an interval-timer register bank.
// Latency: writes complete in the request cycle; reads return data one cycle after the request.
// Backpressure: combinational waitrequest, high only in the first cycle of a read.
module nano_mem_responder #(
    parameter int WIDTHA  = 12,
    parameter int WIDTHD  = 32,
    parameter int IOBASE  = 'hff0,
    parameter     RAMINIT = ""
) (
    input  logic                clock,
    input  logic                areset_n,
    input  logic [WIDTHA-1:0]   address,
    input  logic [WIDTHD-1:0]   writedata,
    output logic [WIDTHD-1:0]   readdata,
    input  logic [WIDTHD/8-1:0] byteenable,
    input  logic                read,
    input  logic                write,
    output logic                waitrequest,
    output logic                irq
);
    localparam int                NB       = WIDTHD / 8;
    localparam logic [WIDTHA-1:0] IO_FIRST = WIDTHA'(IOBASE);

    logic [WIDTHD-1:0] mem [0:IOBASE-1];

    logic              rd_pend;
    logic [WIDTHD-1:0] count;
    logic [WIDTHD-1:0] reload;
    logic [1:0]        ctrl;
    logic              pending;

    logic              is_io;
    logic [WIDTHA-1:0] io_off;
    logic              sel_count;
    logic              sel_reload;
    logic              sel_ctrl;
    logic              sel_status;
    logic              rd_accept;
    logic              terminal;
    logic [WIDTHD-1:0] reg_rdata;
    logic [WIDTHD-1:0] rd_value;

    assign is_io      = address >= IO_FIRST;
    assign io_off     = address - IO_FIRST;
    assign sel_count  = is_io && (io_off == WIDTHA'(0));
    assign sel_reload = is_io && (io_off == WIDTHA'(1));
    assign sel_ctrl   = is_io && (io_off == WIDTHA'(2));
    assign sel_status = is_io && (io_off == WIDTHA'(3));

    // A simultaneous write suppresses the read entirely, so no wait state is inserted.
    assign waitrequest = read & ~write & ~rd_pend;
    assign rd_accept   = waitrequest;
    assign terminal    = ctrl[0] && (count == '0);

    always_comb begin
        reg_rdata = '0;
        if (sel_count)
            reg_rdata = count;
        else if (sel_reload)
            reg_rdata = reload;
        else if (sel_ctrl)
            reg_rdata = WIDTHD'(ctrl);
        else if (sel_status)
            reg_rdata = WIDTHD'(pending);
    end

    assign rd_value = is_io ? reg_rdata : mem[address];

    always_ff @(posedge clock) begin
        if (write && !is_io) begin
            for (int i = 0; i < NB; i++) begin
                if (byteenable[i])
                    mem[address][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            rd_pend  <= 1'b0;
            readdata <= '0;
            irq      <= 1'b0;
            count    <= '0;
            reload   <= '0;
            ctrl     <= 2'b00;
            pending  <= 1'b0;
        end else begin
            // PEND always returns to IDLE, whether or not the initiator still holds read.
            rd_pend <= rd_accept;
            if (rd_accept)
                readdata <= rd_value;

            irq <= pending & ctrl[1];

            if (ctrl[0])
                count <= (count == '0) ? reload : count - WIDTHD'(1);

            if (write && sel_reload) begin
                reload <= writedata;
                count  <= writedata;
            end
            if (write && sel_ctrl)
                ctrl <= writedata[1:0];

            // Terminal count beats a same-cycle W1C so no expiry is ever lost.
            if (terminal)
                pending <= 1'b1;
            else if (write && sel_status && writedata[0])
                pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nano_mem_responder.sv
// Randomized and directed bench for nano_mem_responder against a cycle-level behavioural model.
module tb_nano_mem_responder;
    localparam logic [11:0] IOB = 12'hff0;

    logic        clock = 1'b0;
    logic        areset_n;
    logic [11:0] address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  byteenable;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    nano_mem_responder #(
        .WIDTHA (12),
        .WIDTHD (32),
        .IOBASE ('hff0),
        .RAMINIT("")
    ) dut (
        .clock      (clock),
        .areset_n   (areset_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .byteenable (byteenable),
        .read       (read),
        .write      (write),
        .waitrequest(waitrequest),
        .irq        (irq)
    );

    // Behavioural model state, as seen by the initiator after each clock edge.
    logic [31:0] m_ram [0:63];
    logic        m_pend;
    logic [31:0] m_rdata;
    logic        m_irq;
    logic [31:0] m_count;
    logic [31:0] m_reload;
    logic [1:0]  m_ctrl;
    logic        m_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend    = 1'b0;
        m_rdata   = 32'h0;
        m_irq     = 1'b0;
        m_count   = 32'h0;
        m_reload  = 32'h0;
        m_ctrl    = 2'b00;
        m_pending = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        logic [11:0] off;
        if (a < IOB)
            return (a < 12'd64) ? m_ram[a[5:0]] : 32'h0;
        off = a - IOB;
        case (off)
            12'd0:   return m_count;
            12'd1:   return m_reload;
            12'd2:   return {30'h0, m_ctrl};
            12'd3:   return {31'h0, m_pending};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] n_count;
        logic        n_pending;
        logic        n_irq;
        logic        expiring;
        logic [11:0] off;
        n_irq     = m_pending & m_ctrl[1];
        expiring  = m_ctrl[0] && (m_count == 32'h0);
        off       = address - IOB;
        n_count   = m_count;
        n_pending = m_pending;

        if (read && !write && !m_pend) begin
            m_rdata = model_read(address);
            m_pend  = 1'b1;
        end else begin
            m_pend  = 1'b0;
        end

        if (m_ctrl[0]) begin
            if (expiring) begin
                n_count   = m_reload;
                n_pending = 1'b1;
            end else begin
                n_count = m_count - 32'd1;
            end
        end

        if (write) begin
            if (address < IOB) begin
                if (address < 12'd64)
                    for (int i = 0; i < 4; i++)
                        if (byteenable[i]) m_ram[address[5:0]][8*i +: 8] = writedata[8*i +: 8];
            end else begin
                case (off)
                    12'd1: begin m_reload = writedata; n_count = writedata; end
                    12'd2: m_ctrl = writedata[1:0];
                    12'd3: if (writedata[0] && !expiring) n_pending = 1'b0;
                    default: ;
                endcase
            end
        end

        m_count   = n_count;
        m_pending = n_pending;
        m_irq     = n_irq;
    endtask

    // One bus cycle: check outputs mid-cycle, then advance the model on the edge.
    task automatic tick();
        @(negedge clock);
        check("waitrequest", {31'h0, waitrequest}, {31'h0, read & ~write & ~m_pend});
        check("readdata", readdata, m_rdata);
        check("irq", {31'h0, irq}, {31'h0, m_irq});
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be; write = 1'b1; read = 1'b0;
        tick();
        write = 1'b0;
    endtask

    task automatic do_read(input logic [11:0] a, output logic [31:0] d);
        address = a; read = 1'b1; write = 1'b0;
        tick();
        tick();
        read = 1'b0;
        d = readdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          n;
        areset_n = 1'b0; read = 1'b0; write = 1'b0;
        address = 12'h0; writedata = 32'h0; byteenable = 4'h0;
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        check("rst_readdata", readdata, 32'h0);
        check("rst_wait", {31'h0, waitrequest}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        areset_n = 1'b1;

        // Basic write then two-cycle read
        address = 12'h010; writedata = 32'hdeadbeef; byteenable = 4'hf; write = 1'b1;
        #1 check("t1_wr_wait", {31'h0, waitrequest}, 32'h0);
        tick();
        write = 1'b0; read = 1'b1;
        #1 check("t1_rd_wait1", {31'h0, waitrequest}, 32'h1);
        tick();
        check("t1_rd_wait2", {31'h0, waitrequest}, 32'h0);
        tick();
        read = 1'b0;
        check("t1_data", readdata, 32'hdeadbeef);

        // Byte lanes
        do_write(12'h010, 32'h11223344, 4'hf);
        do_write(12'h010, 32'haabbccdd, 4'b0101);
        do_read(12'h010, d);
        check("t2_lanes", d, 32'h11bb33dd);

        // Timer period and irq delay
        do_write(IOB + 12'd1, 32'd3, 4'h0);
        do_write(IOB + 12'd2, 32'h3, 4'h0);
        n = 0;
        while (irq !== 1'b1 && n < 20) begin tick(); n++; end
        check("t3_irq_delay", n, 5);
        do_read(IOB + 12'd3, d);
        check("t3_status", d, 32'h1);

        // W1C colliding with terminal count, then a clearing W1C
        n = 0;
        while (m_count != 32'h0 && n < 10) begin tick(); n++; end
        do_write(IOB + 12'd3, 32'h1, 4'h0);
        do_write(IOB + 12'd3, 32'h1, 4'h0);
        check("t4_collision_irq", {31'h0, irq}, 32'h1);
        tick();
        check("t4_irq_fall", {31'h0, irq}, 32'h0);
        n = 0;
        while (irq !== 1'b1 && n < 20) begin tick(); n++; end
        check("t4_rearm", n, 3);

        // Aborted read
        address = 12'h010; read = 1'b1;
        tick();
        read = 1'b0;
        #1 check("t5_abort_wait", {31'h0, waitrequest}, 32'h0);
        tick();
        read = 1'b1;
        #1 check("t5_rd2_wait1", {31'h0, waitrequest}, 32'h1);
        tick();
        check("t5_rd2_wait2", {31'h0, waitrequest}, 32'h0);
        tick();
        read = 1'b0;
        check("t5_rd2_data", readdata, 32'h11bb33dd);

        // Reset in the middle of a read
        address = 12'h020; read = 1'b1;
        do_write(12'h020, 32'hcafef00d, 4'hf);
        read = 1'b1; address = 12'h020;
        tick();
        check("t5_pre_irq", {31'h0, irq}, 32'h1);
        areset_n = 1'b0; read = 1'b0;
        model_reset();
        #1;
        check("t5_rst_wait", {31'h0, waitrequest}, 32'h0);
        check("t5_rst_data", readdata, 32'h0);
        check("t5_rst_irq", {31'h0, irq}, 32'h0);
        @(posedge clock);
        #2 areset_n = 1'b1;
        do_read(IOB + 12'd0, d); check("t5_count0", d, 32'h0);
        do_read(IOB + 12'd1, d); check("t5_reload0", d, 32'h0);
        do_read(IOB + 12'd2, d); check("t5_ctrl0", d, 32'h0);
        do_read(IOB + 12'd3, d); check("t5_status0", d, 32'h0);

        // Read and write together: write wins, no wait state
        address = 12'h020; writedata = 32'h5a5a5a5a; byteenable = 4'hf;
        read = 1'b1; write = 1'b1;
        #1 check("t6_wait", {31'h0, waitrequest}, 32'h0);
        tick();
        read = 1'b0; write = 1'b0;
        do_read(12'h020, d);
        check("t6_data", d, 32'h5a5a5a5a);

        // Fill the RAM window so every random read has a defined value
        for (int a = 0; a < 64; a++) do_write(12'(a), $urandom, 4'hf);

        for (int c = 0; c < 1500; c++) begin
            write = 1'b0;
            if (m_pend) begin
                read = ($urandom_range(0, 7) != 0);
            end else begin
                read = 1'b0;
                case ($urandom_range(0, 5))
                    1, 2: begin
                        read = 1'b1;
                        address = $urandom_range(0, 1) ? 12'($urandom_range(0, 63))
                                                       : IOB + 12'($urandom_range(0, 15));
                    end
                    3: begin
                        write = 1'b1; address = 12'($urandom_range(0, 63));
                        writedata = $urandom; byteenable = 4'($urandom_range(0, 15));
                    end
                    4: begin
                        write = 1'b1; address = IOB + 12'($urandom_range(0, 15));
                        byteenable = 4'($urandom_range(0, 15));
                        writedata = (address == IOB + 12'd1) ? 32'($urandom_range(0, 6)) : $urandom;
                    end
                    5: begin
                        read = 1'b1; write = 1'b1; address = 12'($urandom_range(0, 63));
                        writedata = $urandom; byteenable = 4'($urandom_range(0, 15));
                    end
                    default: ;
                endcase
            end
            tick();
        end
        read = 1'b0; write = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
